btn_conditioner: RTL and testbench

Front-end stage for the stopwatch counter: turns the raw board push-buttons into the clean control levels that counter consumes. It synchronises and debounces three buttons, toggles a `pause` level, and stretches `lap` so the 100 Hz counter clock samples it exactly once. It also runs a view-select state machine that drives the one-hot `lap1`/`lap2`/`lap3` display selects.

---
 rtl/btn_conditioner_if.sv | 24 ++
 rtl/btn_conditioner.sv | 162 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button/front-panel bundle between the raw board buttons, btn_conditioner and the stopwatch counter.
// The slave side is the conditioner; the master side drives the raw buttons and consumes the conditioned levels.
interface btn_conditioner_if;
  logic       btn_pause_raw;
  logic       btn_lap_raw;
  logic       btn_view_raw;
  logic       pause;
  logic       lap;
  logic       lap1;
  logic       lap2;
  logic       lap3;
  logic       clear;
  logic [2:0] btn_db;

  modport master (
    output btn_pause_raw, btn_lap_raw, btn_view_raw,
    input  pause, lap, lap1, lap2, lap3, clear, btn_db
  );

  modport slave (
    input  btn_pause_raw, btn_lap_raw, btn_view_raw,
    output pause, lap, lap1, lap2, lap3, clear, btn_db
  );
endinterface

// File: rtl/btn_conditioner.sv
// Stopwatch front end: synchronise/debounce pause, lap and view buttons, toggle pause, stretch lap, cycle lap views.
// Optional long-press clear on the pause button is enabled by defining BTN_LONG_PRESS_CLEAR_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LAP_HOLD        = 500002,
  parameter int LONG_CYCLES     = 100000000
) (
  input logic              clk_50M,
  input logic              reset_n,
  btn_conditioner_if.slave io
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int                HOLD_W    = $clog2(LAP_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LAP_HOLD);

  typedef enum logic [1:0] {LIVE, VIEW1, VIEW2, VIEW3} view_t;

  // Button vectors are ordered {view, lap, pause}
  logic [2:0]        raw;
  logic [2:0]        s1;
  logic [2:0]        s2;
  logic [2:0]        db;
  logic [2:0]        db_q;
  logic [2:0]        rise;
  logic [CNT_W-1:0]  cnt [3];
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  view_t             state;
  logic              pause_r;
  logic              lap_r;
  logic              lap1_r;
  logic              lap2_r;
  logic              lap3_r;
  logic              clear_r;
  logic              long_hit;

  assign raw  = {io.btn_view_raw, io.btn_lap_raw, io.btn_pause_raw};
  assign rise = db & ~db_q;

  // Synchronizer and debounce
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // lap is registered from the next hold count so it rises in the same edge the stretch is loaded
  always_comb begin
    hold_nxt = hold_cnt;
    if (rise[1] && (hold_cnt == '0)) hold_nxt = HOLD_LOAD;
    else if (hold_cnt != '0)         hold_nxt = hold_cnt - 1'b1;
  end

`ifdef BTN_LONG_PRESS_CLEAR_EN
  localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_armed;

  assign long_hit = db[0] && long_armed && (long_cnt == LONG_LAST);

  // Long-press timer; disarms after firing until debounced pause falls
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      long_cnt   <= '0;
      long_armed <= 1'b1;
    end else if (!db[0]) begin
      long_cnt   <= '0;
      long_armed <= 1'b1;
    end else if (long_armed) begin
      if (long_hit) begin
        long_cnt   <= '0;
        long_armed <= 1'b0;
      end else begin
        long_cnt <= long_cnt + 1'b1;
      end
    end
  end
`else
  // LONG_CYCLES has no effect in this build; a negative value is meaningless, so this is always 0
  assign long_hit = (LONG_CYCLES < 0);
`endif

  // Control: pause toggle, lap stretch, view FSM and clear pulse
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      pause_r  <= 1'b0;
      lap_r    <= 1'b0;
      hold_cnt <= '0;
      state    <= LIVE;
      lap1_r   <= 1'b0;
      lap2_r   <= 1'b0;
      lap3_r   <= 1'b0;
      clear_r  <= 1'b0;
    end else begin
      clear_r <= long_hit;
      if (long_hit) begin
        pause_r  <= 1'b1;
        lap_r    <= 1'b0;
        hold_cnt <= '0;
        state    <= LIVE;
        lap1_r   <= 1'b0;
        lap2_r   <= 1'b0;
        lap3_r   <= 1'b0;
      end else begin
        if (rise[0]) pause_r <= ~pause_r;
        hold_cnt <= hold_nxt;
        lap_r    <= (hold_nxt != '0);
        if (rise[2]) begin
          case (state)
            LIVE: begin
              state <= VIEW1;
              {lap3_r, lap2_r, lap1_r} <= 3'b001;
            end
            VIEW1: begin
              state <= VIEW2;
              {lap3_r, lap2_r, lap1_r} <= 3'b010;
            end
            VIEW2: begin
              state <= VIEW3;
              {lap3_r, lap2_r, lap1_r} <= 3'b100;
            end
            VIEW3: begin
              state <= LIVE;
              {lap3_r, lap2_r, lap1_r} <= 3'b000;
            end
          endcase
        end
      end
    end
  end

  assign io.pause  = pause_r;
  assign io.lap    = lap_r;
  assign io.lap1   = lap1_r;
  assign io.lap2   = lap2_r;
  assign io.lap3   = lap3_r;
  assign io.clear  = clear_r;
  assign io.btn_db = db;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed button presses queue the expected output changes,
// and a monitor compares every observed output change (value and clock edge) against that queue.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int H  = 10;
  localparam int LC = 20;

  // Bit positions in the observed output word
  localparam int PAUSE = 0;
  localparam int LAP   = 1;
  localparam int CLR   = 5;
  localparam int DBP   = 6;
  localparam int DBL   = 7;
  localparam int DBV   = 8;

  typedef struct {
    int         c;
    logic [8:0] v;
  } exp_t;

  logic       clk_50M;
  logic       reset_n;
  logic [2:0] raw;
  logic [8:0] o;
  logic [8:0] ew;
  logic       mon_en = 1'b0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       q[$];
  logic [2:0] sel_tbl [6];

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LAP_HOLD       (H),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk_50M(clk_50M),
    .reset_n(reset_n),
    .io     (bus)
  );

  assign bus.btn_pause_raw = raw[0];
  assign bus.btn_lap_raw   = raw[1];
  assign bus.btn_view_raw  = raw[2];
  assign o = {bus.btn_db, bus.clear, bus.lap3, bus.lap2, bus.lap1, bus.lap, bus.pause};

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic push(input int c, input logic [8:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic tap(input int idx, input int hold);
    raw[idx] = 1'b1;
    repeat (hold) @(negedge clk_50M);
    raw[idx] = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [8:0] req);
    vectors++;
    if (o !== req) begin
      miscompares++;
      $display("FAIL %s cyc %0d got %b required %b", name, cyc, o, req);
    end
  endtask

  // Monitor: every change of the output word consumes one scoreboard entry
  initial begin : monitor
    logic [8:0] last;
    exp_t       e;
    last = '0;
    wait (mon_en);
    forever begin
      @(negedge clk_50M);
      if ($countones(o[4:2]) > 1) begin
        miscompares++;
        $display("FAIL onehot cyc %0d got selects %b required at most one high", cyc, o[4:2]);
      end
      if (o !== last) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc %0d got %b required %b (no change)", cyc, o, last);
        end else begin
          e = q.pop_front();
          if ((o !== e.v) || (cyc != e.c)) begin
            miscompares++;
            $display("FAIL change cyc %0d got %b required %b at cyc %0d", cyc, o, e.v, e.c);
          end
        end
        last = o;
      end
    end
  end

  initial begin : stim
    int   b;
    exp_t e;
    reset_n = 1'b0;
    raw     = '0;
    ew      = '0;
    sel_tbl = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010};

    repeat (3) @(negedge clk_50M);
    check_now("reset_hold", 9'b0);
    reset_n = 1'b1;
    @(negedge clk_50M);
    check_now("reset_release", 9'b0);
    mon_en = 1'b1;

    // Pause held 12 cycles: db at +6, pause at +7, db falls 6 after release
    b = cyc;
    ew[DBP] = 1'b1; push(b + 6, ew);
    ew[PAUSE] = 1'b1; push(b + 7, ew);
    ew[DBP] = 1'b0; push(b + 18, ew);
    tap(0, 12);
    repeat (8) @(negedge clk_50M);

    // Second pause press toggles back to 0
    b = cyc;
    ew[DBP] = 1'b1; push(b + 6, ew);
    ew[PAUSE] = 1'b0; push(b + 7, ew);
    ew[DBP] = 1'b0; push(b + 11, ew);
    tap(0, 5);
    repeat (10) @(negedge clk_50M);

    // Glitches 3 high / 1 low / 3 high never reach db
    tap(0, 3);
    @(negedge clk_50M);
    tap(0, 3);
    repeat (8) @(negedge clk_50M);

    // Then a stable press is accepted
    b = cyc;
    ew[DBP] = 1'b1; push(b + 6, ew);
    ew[PAUSE] = 1'b1; push(b + 7, ew);
    ew[DBP] = 1'b0; push(b + 14, ew);
    tap(0, 8);
    repeat (10) @(negedge clk_50M);

    // Lap stretch with a second press landing mid-hold (dropped)
    b = cyc;
    ew[DBL] = 1'b1; push(b + 6, ew);
    ew[LAP] = 1'b1; push(b + 7, ew);
    ew[DBL] = 1'b0; push(b + 11, ew);
    ew[DBL] = 1'b1; push(b + 15, ew);
    ew[LAP] = 1'b0; push(b + 17, ew);
    ew[DBL] = 1'b0; push(b + 20, ew);
    tap(1, 5);
    repeat (4) @(negedge clk_50M);
    tap(1, 5);
    repeat (11) @(negedge clk_50M);

    // Press after the hold ends gives a fresh 10-cycle pulse
    b = cyc;
    ew[DBL] = 1'b1; push(b + 6, ew);
    ew[LAP] = 1'b1; push(b + 7, ew);
    ew[DBL] = 1'b0; push(b + 11, ew);
    ew[LAP] = 1'b0; push(b + 17, ew);
    tap(1, 5);
    repeat (15) @(negedge clk_50M);

    // View presses: LIVE -> 1 -> 2 -> 3 -> LIVE -> 1 -> 2
    for (int k = 0; k < 6; k++) begin
      b = cyc;
      ew[DBV] = 1'b1; push(b + 6, ew);
      ew[4:2] = sel_tbl[k]; push(b + 7, ew);
      ew[DBV] = 1'b0; push(b + 11, ew);
      tap(2, 5);
      repeat (5) @(negedge clk_50M);
    end

    // Reset mid-stretch in VIEW2 with pause high clears everything next cycle
    b = cyc;
    ew[DBL] = 1'b1; push(b + 6, ew);
    ew[LAP] = 1'b1; push(b + 7, ew);
    ew = '0; push(b + 11, ew);
    tap(1, 5);
    repeat (5) @(negedge clk_50M);
    reset_n = 1'b0;
    @(negedge clk_50M);
    reset_n = 1'b1;
    @(negedge clk_50M);
    check_now("first_cycle_after_reset", 9'b0);
    repeat (5) @(negedge clk_50M);

    // Short pause press, then a view press, then a long pause hold
    b = cyc;
    ew[DBP] = 1'b1; push(b + 6, ew);
    ew[PAUSE] = 1'b1; push(b + 7, ew);
    ew[DBP] = 1'b0; push(b + 11, ew);
    tap(0, 5);
    repeat (5) @(negedge clk_50M);
    b = cyc;
    ew[DBV] = 1'b1; push(b + 6, ew);
    ew[2] = 1'b1; push(b + 7, ew);
    ew[DBV] = 1'b0; push(b + 11, ew);
    tap(2, 5);
    repeat (5) @(negedge clk_50M);

    b = cyc;
    ew[DBP] = 1'b1; push(b + 6, ew);
    ew[PAUSE] = 1'b0; push(b + 7, ew);
`ifdef BTN_LONG_PRESS_CLEAR_EN
    ew[CLR] = 1'b1; ew[PAUSE] = 1'b1; ew[4:2] = 3'b000; push(b + 26, ew);
    ew[CLR] = 1'b0; push(b + 27, ew);
`endif
    ew[DBP] = 1'b0; push(b + 51, ew);
    tap(0, 45);
    repeat (10) @(negedge clk_50M);

    repeat (20) @(negedge clk_50M);
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_change got no change required %b at cyc %0d", e.v, e.c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
